// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a programmable pattern and length,
// overlapping or non-overlapping mode, a registered hit pulse and a saturating hit counter.
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter logic [PAT_W-1:0] PAT_RST = 8'b0001_0010,
    parameter int LEN_RST = 5,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat,
    output logic [LEN_W-1:0] fill
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_R0 = LEN_W'((LEN_RST > PAT_W) ? PAT_W : LEN_RST);

    // The oldest history bit is never compared, so only PAT_W-1 bits are kept.
    logic [PAT_W-2:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic             r_z;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_cand;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_n;
    logic [LEN_W-1:0] w_len_c;
    logic             w_hit;

    always_comb begin
        w_cand   = {r_hist, x};
        w_mask   = ~({PAT_W{1'b1}} << r_len);
        w_fill_n = (r_fill == LEN_MAX) ? r_fill : r_fill + 1'b1;
        w_len_c  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        w_hit    = x_valid && !cfg_we && (r_len != '0) && (w_fill_n >= r_len)
                   && (((w_cand ^ r_pat) & w_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PAT_RST;
            r_len  <= LEN_R0;
            r_ovl  <= 1'b1;
            r_z    <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_z <= w_hit;
            if (cfg_we) begin
                r_pat  <= cfg_pattern;
                r_len  <= w_len_c;
                r_ovl  <= cfg_overlap;
                r_hist <= '0;
                r_fill <= '0;
            end else if (x_valid) begin
                r_hist <= w_cand[PAT_W-2:0];
                r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_n;
            end
            if (cnt_clr)
                r_cnt <= '0;
            else if (w_hit && !(&r_cnt))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign z       = r_z;
    assign hit_cnt = r_cnt;
    assign cnt_sat = &r_cnt;
    assign fill    = r_fill;
endmodule
